// File: rtl/riscv_rv12_pkg.sv
// RV12 identification constants and machine-information CSR addresses.
package riscv_rv12_pkg;

  // Architecture and spec revision identifiers
  localparam int unsigned ARCHID       = 12;
  localparam int unsigned REVPRV_MAJOR = 1;
  localparam int unsigned REVPRV_MINOR = 10;
  localparam int unsigned REVUSR_MAJOR = 2;
  localparam int unsigned REVUSR_MINOR = 2;

  // Machine-information CSR addresses
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

endpackage

// File: rtl/riscv_id_rsp_fifo.sv
// Generic 2-deep valid/ready FIFO; head entry is presented directly from storage.
module riscv_id_rsp_fifo #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_valid_i,
  output logic push_ready_o,
  input  T     push_data_i,
  output logic pop_valid_o,
  input  logic pop_ready_i,
  output T     pop_data_o
);

  T           mem [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign push_ready_o = (count != 2'd2);
  assign pop_valid_o  = (count != 2'd0);
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_valid_o && pop_ready_i;
  assign pop_data_o   = mem[rptr];

  // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data_i;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/riscv_id_csr_responder.sv
// Answers read requests for mvendorid/marchid/mimpid/mhartid with a 2-entry response buffer.
module riscv_id_csr_responder
  import riscv_rv12_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned JEDEC_BANK = 0,
  parameter int unsigned JEDEC_ID   = 0,
  parameter int unsigned HARTID     = 0,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [11:0]         req_addr_i,
  input  logic                req_we_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [XLEN-1:0]     rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } id_rsp_t;

  id_rsp_t rsp_d;
  id_rsp_t rsp_q;
  logic    rst_q;
  logic    fifo_ready;
  logic    accept;
  logic    unused_wdata;

  // All target CSRs are read-only, so write data never reaches the response
  assign unused_wdata = ^req_wdata_i;

  // Holds requests off until the first clock edge after reset release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_q <= 1'b1;
    else       rst_q <= 1'b0;
  end

  assign req_ready_o = fifo_ready && !rst_q;
  assign accept      = req_valid_i && req_ready_o;

  // Address decode; any write or unmapped read faults with zero data
  always_comb begin
    rsp_d       = '0;
    rsp_d.err   = 1'b1;
    if (!req_we_i) begin
      case (req_addr_i)
        CSR_MVENDORID: begin
          rsp_d.rdata = {(XLEN-7)'(JEDEC_BANK), 7'(JEDEC_ID)};
          rsp_d.err   = 1'b0;
        end
        CSR_MARCHID: begin
          rsp_d.rdata = XLEN'(ARCHID);
          rsp_d.err   = 1'b0;
        end
        CSR_MIMPID: begin
          rsp_d.rdata = XLEN'({8'(REVUSR_MAJOR), 8'(REVUSR_MINOR),
                               8'(REVPRV_MAJOR), 8'(REVPRV_MINOR)});
          rsp_d.err   = 1'b0;
        end
        CSR_MHARTID: begin
          rsp_d.rdata = XLEN'(HARTID);
          rsp_d.err   = 1'b0;
        end
        default: begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of faulted requests, taken at acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (accept && rsp_d.err && (err_cnt_o != {ERRCNT_W{1'b1}})) begin
      err_cnt_o <= err_cnt_o + ERRCNT_W'(1);
    end
  end

  riscv_id_rsp_fifo #(
    .T (id_rsp_t)
  ) u_rsp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_valid_i (req_valid_i && !rst_q),
    .push_ready_o (fifo_ready),
    .push_data_i  (rsp_d),
    .pop_valid_o  (rsp_valid_o),
    .pop_ready_i  (rsp_ready_i),
    .pop_data_o   (rsp_q)
  );

  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_riscv_id_csr_responder.sv
// Scoreboard bench for the machine-information CSR responder.
module tb_riscv_id_csr_responder;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ERRCNT_W = 2;
  localparam int unsigned HARTID   = 3;
  localparam int unsigned JB       = 5;
  localparam int unsigned JID      = 26;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [11:0]         req_addr;
  logic                req_we;
  logic [XLEN-1:0]     req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [XLEN-1:0]     rsp_rdata;
  logic                rsp_err;
  logic [ERRCNT_W-1:0] err_cnt;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  logic        stall_q = 1'b0;
  logic [31:0] stall_d;
  logic        stall_e;

  riscv_id_csr_responder #(
    .XLEN       (XLEN),
    .JEDEC_BANK (JB),
    .JEDEC_ID   (JID),
    .HARTID     (HARTID),
    .ERRCNT_W   (ERRCNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request, wait (bounded) for acceptance, queue its expected response
  task automatic send(input logic [11:0] addr, input logic we, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_e);
    int w;
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
    exp_q.push_back('{rdata: exp_d, err: exp_e});
    if (exp_e) exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 20) begin
      tick();
      w++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every delivered response and hold-stability under backpressure
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && rsp_valid) begin
        check("stable_rdata", 64'(rsp_rdata), 64'(stall_d));
        check("stable_err", 64'(rsp_err), 64'(stall_e));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
      stall_q = rsp_valid && !rsp_ready;
      stall_d = rsp_rdata;
      stall_e = rsp_err;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    #3;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_cnt", 64'(err_cnt), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    check("ready_low_until_edge", 64'(req_ready), 64'd0);
    tick();
    check("ready_after_release", 64'(req_ready), 64'd1);

    // marchid with one-cycle latency
    send(12'hF12, 1'b0, 32'h0, 32'h0000000C, 1'b0);
    check("latency_valid", 64'(rsp_valid), 64'd1);

    // mimpid then mhartid back-to-back
    send(12'hF13, 1'b0, 32'h0, 32'h0202010A, 1'b0);
    check("b2b_ready", 64'(req_ready), 64'd1);
    send(12'hF14, 1'b0, 32'h0, 32'h00000003, 1'b0);
    check("b2b_ready2", 64'(req_ready), 64'd1);
    send(12'hF11, 1'b0, 32'h0, 32'h0000029A, 1'b0);
    wait_drain();

    // Faults: write to mapped CSR, unmapped read
    send(12'hF11, 1'b1, 32'h0000FFFF, 32'h0, 1'b1);
    check("cnt_after_write", 64'(err_cnt), 64'd1);
    send(12'h300, 1'b0, 32'h0, 32'h0, 1'b1);
    check("cnt_after_unmapped", 64'(err_cnt), 64'd2);
    wait_drain();

    // Backpressure: two accepted, third held until drain starts
    rsp_ready = 1'b0;
    send(12'hF12, 1'b0, 32'h0, 32'h0000000C, 1'b0);
    send(12'hF14, 1'b0, 32'h0, 32'h00000003, 1'b0);
    check("full_ready_low", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    req_addr  = 12'hF13;
    req_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_ready_low", 64'(req_ready), 64'd0);
      check("held_valid", 64'(rsp_valid), 64'd1);
      check("held_head", 64'(rsp_rdata), 64'h0000000C);
    end
    rsp_ready = 1'b1;
    send(12'hF13, 1'b0, 32'h0, 32'h0202010A, 1'b0);
    wait_drain();

    // Async reset with two faulting responses buffered
    rsp_ready = 1'b0;
    send(12'hF12, 1'b1, 32'h1, 32'h0, 1'b1);
    send(12'hABC, 1'b0, 32'h0, 32'h0, 1'b1);
    check("pre_rst_cnt", 64'(err_cnt), 64'd3);
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_cnt", 64'(err_cnt), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("rerelease_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("no_stale_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end

    // Saturation of the 2-bit error counter
    begin
      logic [11:0] fa [5];
      logic        fw [5];
      int          sat_exp [5];
      fa = '{12'hF11, 12'h300, 12'hF14, 12'h000, 12'hF15};
      fw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      sat_exp = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
        send(fa[i], fw[i], 32'hDEAD, 32'h0, 1'b1);
        check("sat_cnt", 64'(err_cnt), 64'(sat_exp[i]));
        check("sat_model", 64'(err_cnt), 64'(exp_cnt));
      end
    end
    wait_drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_id_csr_responder.md
Name: riscv_id_csr_responder

Overview:
- Responder side of the machine-information CSR read path. Answers CSR access requests for mvendorid, marchid, mimpid and mhartid.
- Returned values come from the shared RV12 identification constants: architecture ID and privileged/user spec revisions.
- Sits behind the CSR access initiator, either the core's CSR stage or the debug unit.
- Buffers up to two responses so the request side can sustain one access per cycle under response backpressure.

Parameters:
- XLEN, 32, data width; 32 or 64.
- JEDEC_BANK, 0, mvendorid bank field, bits [XLEN-1:7].
- JEDEC_ID, 0, mvendorid offset field, bits [6:0].
- HARTID, 0, value returned for mhartid.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_addr_i  in  12  CSR address.
- req_we_i  in  1  request is a write.
- req_wdata_i  in  XLEN  write data; ignored, since all target CSRs are read-only.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid and ready are both high.
- rsp_rdata_o  out  XLEN  read data.
- rsp_err_o  out  1  access fault: illegal write or unmapped address.
- err_cnt_o  out  ERRCNT_W  saturating count of faulted requests.

Behaviour:
- Reset (async assert, sync deassert internal to the design): response buffer empty, so rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, err_cnt_o=0.
  - req_ready_o=0 while rst_i is high; it equals 1 from the first clock after deassertion.
- Address map (XLEN-wide, zero-extended):
  - 0xF11 mvendorid = {JEDEC_BANK, JEDEC_ID[6:0]}
  - 0xF12 marchid = ARCHID (12)
  - 0xF13 mimpid = {REVUSR_MAJOR[7:0], REVUSR_MINOR[7:0], REVPRV_MAJOR[7:0], REVPRV_MINOR[7:0]}, which is 0x0202010A
  - 0xF14 mhartid = HARTID
- Decode:
  - Mapped address with req_we_i=0: rdata = value, err=0.
  - req_we_i=1 to any address: rdata=0, err=1.
  - Unmapped read: rdata=0, err=1.
- Response buffer:
  - 2-entry FIFO of {rdata, err}, with 1-bit read and write pointers plus a 2-bit count.
  - The accepted request is decoded combinationally and written into the FIFO on the acceptance edge.
- Latency: response is visible on rsp_valid_o in the cycle after acceptance (1 cycle). No combinational path from req_* to rsp_*.
- req_ready_o = (count < 2). It is registered-equivalent, derived from count only, with no dependence on rsp_ready_i.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When count==2 no push occurs even if rsp_ready_i=1 that cycle, because ready is already low.
- Empty: rsp_valid_o=0; rsp_rdata_o/rsp_err_o hold the last head entry value and must not be used.
- Full (count==2): req_ready_o=0; held requests stay pending and no request is dropped.
- Response stability: while rsp_valid_o=1 and rsp_ready_i=0, rsp_rdata_o/rsp_err_o are stable.
- err_cnt_o:
  - Increments by 1 on each accepted request that decodes err=1.
  - It counts at acceptance, not at response.
  - Saturates at 2^ERRCNT_W-1.
- Reset mid-operation: buffered responses are discarded; in-flight responses are never delivered after reset.

Decomposition:
- Shared package riscv_rv12_pkg (existing):
  - ARCHID and the REVPRV/REVUSR constants stay there.
  - Add localparams CSR_MVENDORID=12'hF11, CSR_MARCHID=12'hF12, CSR_MIMPID=12'hF13, CSR_MHARTID=12'hF14.
  - Add typedef id_rsp_t {logic [XLEN-1:0] rdata; logic err;}, parameterised via XLEN.
- One sub-module is natural: riscv_id_rsp_fifo, a generic 2-deep valid/ready FIFO instantiated with id_rsp_t.
- Decode and the error counter live in the top block.

Test Plan:
- Reset, then a read of 0xF12 with rsp_ready_i=1 -> next cycle rsp_valid_o=1, rdata=0x0000000C, err=0.
- Reads of 0xF13 then 0xF14 back-to-back (HARTID=3) -> two consecutive responses: 0x0202010A then 0x00000003; req_ready_o stays 1 throughout.
- Write of 0xF11 with wdata=0xFFFF -> rdata=0, err=1, err_cnt_o 0->1. A read of 0x300 -> err=1, err_cnt_o=2.
- Backpressure with rsp_ready_i=0 and three requests offered:
  - first two accepted; req_ready_o=0 from the cycle after the second acceptance;
  - response data stays stable;
  - raising rsp_ready_i drains in order, and the third request is then accepted.
- Saturation: ERRCNT_W=2 with five faulting requests -> err_cnt_o sequence 1,2,3,3,3.
- Assert rst_i asynchronously with two responses buffered -> rsp_valid_o=0 and err_cnt_o=0 immediately (before the next edge); no stale response after release.
